apb_xfer_ctrl: RTL

- Sequencing controller for the APB interface datapath.
- Accepts single read/write requests from the AHB-side slave logic and decodes the address to one of three one-hot APB slave selects.
- Drives the APB SETUP and ENABLE phases with registered pwrite/penable/psel/paddr/pwdata, and returns read data or an error to the requester.
- Supports back-to-back transfers: a new request may be accepted in the completing ENABLE cycle, with no IDLE bubble.

---
 rtl/apb_xfer_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_xfer_ctrl.sv
// apb_xfer_ctrl: sequencing controller for the APB side of the bridge.
// Takes single read/write requests, decodes them onto one of three APB slave
// slots, drives the registered SETUP/ENABLE phases and returns a one-cycle
// response (read data or error). A new request may be accepted in the cycle
// that completes ENABLE, so back-to-back transfers run without an IDLE gap.
//
// Optional feature macro: APB_PREADY_EN
//   undefined : no pready port, ENABLE lasts exactly one cycle.
//   defined   : pready input added; ENABLE waits for pready and aborts with
//               an error response after TIMEOUT consecutive wait cycles.
`timescale 1ns/1ps

module apb_xfer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          SLOT_LOG2 = 26,
  parameter int          CNT_W     = 16
`ifdef APB_PREADY_EN
  ,parameter int         TIMEOUT   = 16
`endif
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [31:0]      rsp_rdata,
  output logic             pwrite,
  output logic             penable,
  output logic [2:0]       psel,
  output logic [31:0]      paddr,
  output logic [31:0]      pwdata,
  input  logic [31:0]      prdata,
`ifdef APB_PREADY_EN
  input  logic             pready,
`endif
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t state, state_next;

  // Next-cycle values for every registered output.
  logic             pwrite_next;
  logic             penable_next;
  logic [2:0]       psel_next;
  logic [31:0]      paddr_next;
  logic [31:0]      pwdata_next;
  logic             rsp_valid_next;
  logic             rsp_err_next;
  logic [31:0]      rsp_rdata_next;
  logic [CNT_W-1:0] count_next;

  // Address decode of the incoming request. The unsigned subtraction wraps
  // for addresses below the window, so the explicit >= test is what rejects
  // them; the slot test rejects everything past the third slot.
  logic [31:0] req_off;
  logic [31:0] req_slot;
  logic        req_hit;
  logic [2:0]  req_psel;
  logic        accept;
  logic        enable_done;
  logic        enable_abort;

  assign req_off  = req_addr - BASE_ADDR;
  assign req_slot = req_off >> SLOT_LOG2;
  assign req_hit  = (req_addr >= BASE_ADDR) && (req_slot < 32'd3);
  assign req_psel = 3'b001 << req_slot[1:0];

`ifdef APB_PREADY_EN
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Counts consecutive not-ready ENABLE cycles; cleared in SETUP so every
  // transfer starts its ENABLE phase with a fresh budget.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ENABLE) && !pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign enable_done  = pready;
  assign enable_abort = !pready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
  assign enable_done  = 1'b1;
  assign enable_abort = 1'b0;
`endif

  // Next-state and next-output logic. Registered outputs hold by default;
  // the response outputs default to idle because they are single-cycle pulses.
  // A request can be taken in IDLE or in the completing ENABLE cycle, and in
  // both cases the accept path overwrites whatever the state case decided.
  always_comb begin
    state_next     = state;
    pwrite_next    = pwrite;
    penable_next   = penable;
    psel_next      = psel;
    paddr_next     = paddr;
    pwdata_next    = pwdata;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = 32'd0;
    count_next     = xfer_count;
    req_ready      = 1'b0;
    accept         = 1'b0;

    case (state)
      IDLE: begin
        req_ready    = !Hreset;
        psel_next    = 3'b000;
        penable_next = 1'b0;
      end

      SETUP: begin
        penable_next = 1'b1;
        state_next   = ENABLE;
      end

      ENABLE: begin
        if (enable_done) begin
          req_ready      = !Hreset;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = pwrite ? 32'd0 : prdata;
          count_next     = xfer_count + CNT_W'(1);
          psel_next      = 3'b000;
          penable_next   = 1'b0;
          state_next     = IDLE;
        end else if (enable_abort) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          psel_next      = 3'b000;
          penable_next   = 1'b0;
          state_next     = IDLE;
        end
      end

      ERR: begin
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b1;
        psel_next      = 3'b000;
        penable_next   = 1'b0;
        state_next     = IDLE;
      end

      default: begin
        psel_next    = 3'b000;
        penable_next = 1'b0;
        state_next   = IDLE;
      end
    endcase

    accept = req_valid && req_ready;

    if (accept) begin
      if (req_hit) begin
        psel_next    = req_psel;
        penable_next = 1'b0;
        paddr_next   = req_addr;
        pwdata_next  = req_wdata;
        pwrite_next  = req_write;
        state_next   = SETUP;
      end else begin
        psel_next    = 3'b000;
        penable_next = 1'b0;
        state_next   = ERR;
      end
    end
  end

  // State register.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // APB and response output registers; reset abandons any transfer in flight.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      pwrite     <= 1'b0;
      penable    <= 1'b0;
      psel       <= 3'b000;
      paddr      <= 32'd0;
      pwdata     <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
      xfer_count <= '0;
    end else begin
      pwrite     <= pwrite_next;
      penable    <= penable_next;
      psel       <= psel_next;
      paddr      <= paddr_next;
      pwdata     <= pwdata_next;
      rsp_valid  <= rsp_valid_next;
      rsp_err    <= rsp_err_next;
      rsp_rdata  <= rsp_rdata_next;
      xfer_count <= count_next;
    end
  end

endmodule
